// File: rtl/pkg_system_mdr.sv
// rtl/pkg_system_mdr.sv - shared widths and state encoding for the MDR multiplier
package pkg_system_mdr;

    localparam int IVW  = 8;               // operand width, >= 2
    localparam int PW   = 2 * IVW;         // product width
    localparam int CNTW = $clog2(IVW) + 1; // shift-add step counter width

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MULT,
        FIX,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mdr_mult_ctrl_conv.sv
// rtl/mdr_mult_ctrl_conv.sv - combinational two's complement to sign/magnitude converter
//
// Ports:
//   i_Val   : W-bit two's complement input
//   i_Neg   : 1 forces negation, 0 takes the magnitude by MSB
//   o_Val   : converted value
//   o_Signo : 1 when the result is non-negative, 0 when negated
module sign_mag_conv #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_Val,
    input  logic         i_Neg,
    output logic [W-1:0] o_Val,
    output logic         o_Signo
);

    logic do_neg;

    assign do_neg  = i_Neg | i_Val[W-1];
    assign o_Val   = do_neg ? (~i_Val + W'(1)) : i_Val;
    assign o_Signo = ~do_neg;

endmodule

// File: rtl/mdr_mult_ctrl.sv
// rtl/mdr_mult_ctrl.sv - sequential signed shift-add multiplier controller
//
// Optional feature macro: MDR_MULT_OVF_EN (enables o_Ovf computation).
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_Start   : start request, sampled only in IDLE
//   i_A, i_B  : IVW-bit two's complement operands, captured on accept
//   o_Ready   : high only in IDLE
//   o_Done    : one-cycle result-valid pulse
//   o_Result  : 2*IVW-bit signed product
//   o_Signo   : 1 = positive or zero, 0 = negative
//   o_Ovf     : product does not fit in IVW signed bits
module mdr_mult_ctrl
    import pkg_system_mdr::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_Start,
    input  logic [IVW-1:0] i_A,
    input  logic [IVW-1:0] i_B,
    output logic          o_Ready,
    output logic          o_Done,
    output logic [PW-1:0] o_Result,
    output logic          o_Signo,
    output logic          o_Ovf
);

    mult_state_t     state, state_nxt;
    logic [IVW-1:0]  a_q, b_q;
    logic [IVW-1:0]  mag_a, mag_b;
    logic            s_a, s_b;
    logic [PW-1:0]   acc;
    logic [CNTW-1:0] cnt;
    logic            neg;

    logic [PW-1:0]   conv_in;
    logic            conv_neg;
    logic [PW-1:0]   conv_val;
    logic            conv_signo;

    // A zero product is always reported positive.
    assign neg = (s_a ^ s_b) & (acc != '0);

    // One converter shared across both operand loads and the final fix-up.
    always_comb begin
        conv_in  = '0;
        conv_neg = 1'b0;
        case (state)
            LOAD_A: conv_in = {{IVW{a_q[IVW-1]}}, a_q};
            LOAD_B: conv_in = {{IVW{b_q[IVW-1]}}, b_q};
            FIX: begin
                conv_in  = acc;
                conv_neg = neg;
            end
            default: ;
        endcase
    end

    sign_mag_conv #(.W(PW)) u_conv (
        .i_Val   (conv_in),
        .i_Neg   (conv_neg),
        .o_Val   (conv_val),
        .o_Signo (conv_signo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Start) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = MULT;
            MULT:    if (cnt == CNTW'(IVW - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign o_Ready = (state == IDLE);
    assign o_Done  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            o_Result <= '0;
            o_Signo  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        a_q <= i_A;
                        b_q <= i_B;
                    end
                end
                LOAD_A: begin
                    // -2^(IVW-1) lands on unsigned 2^(IVW-1), which still fits.
                    mag_a <= conv_val[IVW-1:0];
                    s_a   <= a_q[IVW-1];
                end
                LOAD_B: begin
                    mag_b <= conv_val[IVW-1:0];
                    s_b   <= b_q[IVW-1];
                    acc   <= '0;
                    cnt   <= '0;
                end
                MULT: begin
                    if (mag_b[cnt[CNTW-2:0]])
                        acc <= acc + (PW'(mag_a) << cnt);
                    cnt <= cnt + CNTW'(1);
                end
                FIX: begin
                    o_Result <= conv_val;
                    o_Signo  <= conv_signo;
                end
                default: ;
            endcase
        end
    end

`ifdef MDR_MULT_OVF_EN
    logic [IVW:0] hi_bits;

    // Fits in IVW signed bits only when bits [PW-1:IVW-1] are a pure sign run.
    assign hi_bits = conv_val[PW-1:IVW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_Ovf <= 1'b0;
        else if (state == FIX)
            o_Ovf <= ~((&hi_bits) | ~(|hi_bits));
    end
`else
    assign o_Ovf = 1'b0;
`endif

endmodule
